// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable even-ratio clock divider:
// controller state encoding and the divisor legality check.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // A divisor is usable when it is even and in 2 .. 2^cnt_w-2, so that the
  // counter never has to reach its all-ones value and both phases are equal.
  function automatic logic div_legal(input logic [31:0] n, input int cnt_w);
    logic [31:0] max_div;
    max_div = (32'd1 << cnt_w) - 32'd2;
    return (n[0] == 1'b0) && (n >= 32'd2) && (n <= max_div);
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for clk_div_ctrl: counts 0..div-1, flags the terminal cycle
// and produces the registered 50%-duty output clock.
module clk_div_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             active_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             boundary_o,
  output logic             clk_out_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half_div;
  logic             clk_q, clk_d;

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign half_div   = div_i >> 1;
  assign boundary_o = active_i && (cnt_q == (div_i - CNT_W'(1)));
  assign clk_out_o  = clk_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no input
    // combination leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    clk_d = clk_q;
    if (clear_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (load_i) begin
      // Every period starts with its high phase.
      cnt_d = '0;
      clk_d = 1'b1;
    end else if (active_i) begin
      cnt_d = cnt_inc;
      clk_d = (cnt_inc < half_div);
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable, glitch-free even-ratio clock divider controller.
// Holds the OFF/RUN/DRAIN sequencer, the pending-divisor register and the cfg handshake.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             err,
  output logic             clk_out,
  output logic             period_tick,
  output logic             running,
  output logic [CNT_W-1:0] div_cur
);

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

  state_e           state_q;
  logic [CNT_W-1:0] div_cur_q;
  logic [CNT_W-1:0] pend_div_q;
  logic             pend_q;
  logic             err_q;

  logic             boundary;
  logic             xfer;
  logic             cfg_legal;
  logic             stop_now;
  logic             cnt_load;
  logic             cnt_clear;
  logic             active;

  assign active    = (state_q != ST_OFF);
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_legal = div_legal(32'(cfg_div), CNT_W);

  // A period that ends while en is low is the last one; otherwise the
  // boundary rolls straight into the next period (possibly at a new ratio).
  assign stop_now  = boundary && !en;
  assign cnt_clear = stop_now;
  assign cnt_load  = ((state_q == ST_OFF) && en) || (boundary && en);

  clk_div_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_in    (clk_in),
    .rst       (rst),
    .active_i  (active),
    .load_i    (cnt_load),
    .clear_i   (cnt_clear),
    .div_i     (div_cur_q),
    .boundary_o(boundary),
    .clk_out_o (clk_out)
  );

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_OFF;
      div_cur_q  <= DEF_DIV_V;
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= xfer && !cfg_legal;

      unique case (state_q)
        ST_OFF:   if (en) state_q <= ST_RUN;
        ST_RUN:   if (!en) state_q <= boundary ? ST_OFF : ST_DRAIN;
        ST_DRAIN: begin
          if (en)            state_q <= ST_RUN;
          else if (boundary) state_q <= ST_OFF;
        end
        default:  state_q <= ST_OFF;
      endcase

      // A pending divisor is applied at a period boundary; one that was
      // captured on the final boundary before OFF is applied once idle.
      if (pend_q && (boundary || (state_q == ST_OFF))) begin
        div_cur_q <= pend_div_q;
        pend_q    <= 1'b0;
      end else if (xfer && cfg_legal) begin
        if (state_q == ST_OFF) begin
          div_cur_q <= cfg_div;
        end else begin
          pend_div_q <= cfg_div;
          pend_q     <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready   = !pend_q;
  assign err         = err_q;
  assign period_tick = boundary;
  assign running     = active;
  assign div_cur     = div_cur_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: per-cycle expected output samples are
// queued as stimulus is planned and compared as the DUT produces them.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             err;
  logic             clk_out;
  logic             period_tick;
  logic             running;
  logic [CNT_W-1:0] div_cur;

  typedef struct packed {
    logic clk;
    logic tick;
    logic ready;
    logic run;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  clk_div_ctrl #(
    .CNT_W  (CNT_W),
    .DEF_DIV(2)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .err        (err),
    .clk_out    (clk_out),
    .period_tick(period_tick),
    .running    (running),
    .div_cur    (div_cur)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void push(input logic c, input logic t, input logic r, input logic u);
    exp_t e;
    e = '{clk: c, tick: t, ready: r, run: u};
    sb.push_back(e);
  endfunction

  // One full output period of divisor n as seen cycle by cycle.
  function automatic void push_period(input int n, input logic r);
    for (int i = 0; i < n / 2; i++)     push(1'b1, 1'b0, r, 1'b1);
    for (int i = 0; i < n / 2 - 1; i++) push(1'b0, 1'b0, r, 1'b1);
    push(1'b0, 1'b1, r, 1'b1);
  endfunction

  // Monitor: after each rising edge, pop one expected sample and compare.
  task automatic run(input int n, input string tag);
    exp_t e;
    exp_t got;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      got = '{clk: clk_out, tick: period_tick, ready: cfg_ready, run: running};
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL %s cyc %0d: no expected sample queued, got clk/tick/ready/run=%b", tag, i, got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL %s cyc %0d: clk/tick/ready/run got %b want %b", tag, i, got, e);
        end
      end
    end
  endtask

  task automatic cfg_send(input logic [CNT_W-1:0] n, input string tag);
    cfg_valid = 1'b1;
    cfg_div   = n;
    run(1, tag);
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    sb.delete();
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_div(input logic [CNT_W-1:0] want, input string tag);
    vectors++;
    if (div_cur !== want) begin
      miscompares++;
      $display("FAIL %s div_cur got %0d want %0d", tag, div_cur, want);
    end
  endtask

  task automatic check_err(input logic want, input string tag);
    vectors++;
    if (err !== want) begin
      miscompares++;
      $display("FAIL %s err got %b want %b", tag, err, want);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if ({clk_out, period_tick, cfg_ready, running, err} !== 5'b00100) begin
      miscompares++;
      $display("FAIL %s clk/tick/ready/run/err got %b want 00100",
               tag, {clk_out, period_tick, cfg_ready, running, err});
    end
    check_div(8'd2, tag);
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset");
    push(1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 1'b1, 1'b0);
    run(2, "reset_idle");
  endtask

  task automatic test_default_div();
    do_reset();
    en = 1'b1;
    for (int p = 0; p < 4; p++) push_period(2, 1'b1);
    run(8, "div2_run");
    check_err(1'b0, "div2_run");
  endtask

  task automatic test_off_cfg();
    do_reset();
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd6, "off_cfg6");
    check_div(8'd6, "off_cfg6");
    en = 1'b1;
    push_period(6, 1'b1);
    push_period(6, 1'b1);
    run(12, "div6_run");
  endtask

  task automatic test_change();
    do_reset();
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd4, "chg_cfg4");
    check_div(8'd4, "chg_cfg4");
    en = 1'b1;
    push(1'b1, 1'b0, 1'b1, 1'b1);
    push(1'b1, 1'b0, 1'b1, 1'b1);
    run(2, "chg_head");
    // Offer 8 at cnt 1: old period finishes with ready low, then 8-cycle period.
    push(1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 1'b0, 1'b1);
    push_period(8, 1'b1);
    cfg_send(8'd8, "chg_cfg8");
    check_div(8'd4, "chg_pending");
    run(9, "chg_tail");
    check_div(8'd8, "chg_applied");
  endtask

  task automatic test_err();
    do_reset();
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd5, "err_odd");
    check_err(1'b1, "err_odd");
    check_div(8'd2, "err_odd");
    push(1'b0, 1'b0, 1'b1, 1'b0);
    run(1, "err_gap");
    check_err(1'b0, "err_gap");
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd0, "err_zero");
    check_err(1'b1, "err_zero");
    check_div(8'd2, "err_zero");
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd255, "err_max");
    check_err(1'b1, "err_max");
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd254, "legal_max");
    check_err(1'b0, "legal_max");
    check_div(8'd254, "legal_max");
  endtask

  task automatic test_drain();
    do_reset();
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd10, "drain_cfg10");
    en = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b1, 1'b1);
    run(3, "drain_head");
    en = 1'b0;
    for (int i = 0; i < 2; i++) push(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1, 1'b0);
    run(10, "drain_to_off");
    // Restart, drop en, and re-raise it before the period ends.
    en = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b1, 1'b1);
    run(3, "rerun_head");
    en = 1'b0;
    push(1'b1, 1'b0, 1'b1, 1'b1);
    run(1, "rerun_drain");
    en = 1'b1;
    push(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b1, 1'b1);
    push(1'b0, 1'b1, 1'b1, 1'b1);
    push(1'b1, 1'b0, 1'b1, 1'b1);
    push(1'b1, 1'b0, 1'b1, 1'b1);
    run(8, "rerun_continuous");
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd8, "rmid_cfg8");
    en = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 1'b1, 1'b1);
    run(3, "rmid_head");
    push(1'b1, 1'b0, 1'b0, 1'b1);
    cfg_send(8'd6, "rmid_pend6");
    rst = 1'b0;
    #1;
    check_idle_outputs("rmid_async");
    en = 1'b0;
    @(posedge clk_in);
    #1;
    rst = 1'b1;
    en  = 1'b1;
    push_period(2, 1'b1);
    push_period(2, 1'b1);
    run(4, "rmid_restart");
    check_div(8'd2, "rmid_discard");
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd6, "b2b_first");
    push(1'b0, 1'b0, 1'b1, 1'b0);
    cfg_send(8'd4, "b2b_second");
    check_div(8'd4, "b2b");
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b leftover expected samples got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_off_cfg();
    test_change();
    test_err();
    test_drain();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
